// File: rtl/fetch_unit.sv
// Instruction fetch: direct-mapped I-cache with line refill FSM, feeding a circular instruction queue.
// Hit enqueues the same cycle (dispatch visible next cycle); a miss raises mem_req_valid next cycle; a queue full or rdy_in low holds the PC.
module fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                ICACHE_LINES = 64,
    parameter int                LINE_WORDS   = 4,
    parameter int                IQ_DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              mem_rsp_last,
    output logic [ADDR_W-1:0] pred_pc,
    output logic [31:0]       pred_inst,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_target,
    output logic              disp_valid,
    input  logic              disp_ready,
    output logic [31:0]       disp_inst,
    output logic [ADDR_W-1:0] disp_pc,
    output logic [ADDR_W-1:0] disp_fallthrough,
    output logic              disp_pred_taken,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam int IDX_W   = $clog2(ICACHE_LINES);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int WSEL_W  = (OFF_W > 0) ? OFF_W : 1;
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam int PTR_W   = $clog2(IQ_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} fill_state_e;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] fall;
    } iq_entry_t;

    // Cache storage; only the valid bits need reset.
    logic [31:0]      data_q [ICACHE_LINES][LINE_WORDS];
    logic [TAG_W-1:0] tag_q  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] line_vld_q;

    logic [ADDR_W-1:0] pc_q, pc_d;
    fill_state_e       state_q, state_d;
    logic              req_vld_q, req_vld_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [WSEL_W-1:0] beat_q, beat_d;

    iq_entry_t [IQ_DEPTH-1:0] iq_q;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0]  pc_idx, fill_idx;
    logic [WSEL_W-1:0] pc_word;
    logic [TAG_W-1:0]  pc_tag, fill_tag;
    logic              hit, full, enq, deq;
    logic              fill_we, fill_done, line_clr;

    assign pc_idx   = IDX_W'(pc_q >> (2 + OFF_W));
    assign pc_word  = (LINE_WORDS > 1) ? WSEL_W'(pc_q >> 2) : '0;
    assign pc_tag   = TAG_W'(pc_q >> TAG_LSB);
    assign fill_idx = IDX_W'(req_addr_q >> (2 + OFF_W));
    assign fill_tag = TAG_W'(req_addr_q >> TAG_LSB);

    assign hit       = line_vld_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign full      = (cnt_q == CNT_W'(IQ_DEPTH));
    assign disp_valid = (cnt_q != '0) && !redirect_valid;
    assign enq       = rdy_in && hit && !full && !redirect_valid;
    assign deq       = rdy_in && disp_valid && disp_ready;

    assign pred_pc   = pc_q;
    assign pred_inst = hit ? data_q[pc_idx][pc_word] : '0;

    assign mem_req_valid    = req_vld_q;
    assign mem_req_addr     = req_addr_q;
    assign disp_inst        = iq_q[head_q].inst;
    assign disp_pc          = iq_q[head_q].pc;
    assign disp_fallthrough = iq_q[head_q].fall;
    assign disp_pred_taken  = iq_q[head_q].taken;

    always_comb begin
        pc_d   = pc_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (redirect_valid) begin
            pc_d   = redirect_pc;
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (enq) begin
                pc_d   = pred_taken ? pred_target : pc_q + ADDR_W'(4);
                tail_d = tail_q + 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Refill FSM: the target line is invalidated at request time so a partially written line never hits.
    always_comb begin
        state_d    = state_q;
        req_vld_d  = req_vld_q;
        req_addr_d = req_addr_q;
        beat_d     = beat_q;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        line_clr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit && !redirect_valid) begin
                    state_d    = S_REQ;
                    req_vld_d  = 1'b1;
                    req_addr_d = pc_q & LINE_MASK;
                    line_clr   = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d   = S_FILL;
                    req_vld_d = 1'b0;
                    beat_d    = '0;
                end
            end
            S_FILL: begin
                if (mem_rsp_valid) begin
                    fill_we = 1'b1;
                    beat_d  = (LINE_WORDS > 1) ? beat_q + 1'b1 : '0;
                    if (mem_rsp_last) begin
                        fill_done = 1'b1;
                        state_d   = S_IDLE;
                        beat_d    = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q       <= RESET_PC;
            state_q    <= S_IDLE;
            req_vld_q  <= 1'b0;
            req_addr_q <= '0;
            beat_q     <= '0;
            line_vld_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            iq_q       <= '0;
        end else if (rdy_in) begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            req_vld_q  <= req_vld_d;
            req_addr_q <= req_addr_d;
            beat_q     <= beat_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            if (line_clr) begin
                line_vld_q[pc_idx] <= 1'b0;
            end
            if (fill_done) begin
                line_vld_q[fill_idx] <= 1'b1;
            end
            if (enq) begin
                iq_q[tail_q] <= '{inst: pred_inst, pc: pc_q, taken: pred_taken,
                                  fall: pc_q + ADDR_W'(4)};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            data_q[fill_idx][beat_q] <= mem_rsp_data;
        end
        if (rdy_in && fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cold start, taken branch, queue full/wrap, redirect mid-fill, aliasing, reset mid-fill.
module tb_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid, mem_rsp_last;
    logic [31:0] mem_rsp_data;
    logic [31:0] pred_pc, pred_inst, pred_target;
    logic        pred_taken;
    logic        disp_valid, disp_ready, disp_pred_taken;
    logic [31:0] disp_inst, disp_pc, disp_fallthrough;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
        .pred_pc(pred_pc), .pred_inst(pred_inst), .pred_taken(pred_taken), .pred_target(pred_target),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst), .disp_pc(disp_pc),
        .disp_fallthrough(disp_fallthrough), .disp_pred_taken(disp_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hA5A5_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic disp_chk(input string tag, input logic [31:0] pc, input logic tk);
        chk({tag, "_vld"}, 32'(disp_valid), 32'd1);
        chk({tag, "_pc"},  disp_pc, pc);
        chk({tag, "_inst"}, disp_inst, memw(pc));
        chk({tag, "_ft"},  disp_fallthrough, pc + 32'd4);
        chk({tag, "_tk"},  32'(disp_pred_taken), 32'(tk));
    endtask

    // Waits (bounded) for a refill request, checks its address, then accepts it.
    task automatic req_accept(input logic [31:0] a);
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        chk("req_vld", 32'(mem_req_valid), 32'd1);
        chk("req_addr", mem_req_addr, a);
        mem_req_ready = 1'b1;
        @(negedge clk_in);
        mem_req_ready = 1'b0;
    endtask

    task automatic beats(input logic [31:0] a, input int first, input int cnt);
        for (int b = first; b < first + cnt; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = memw(a + 32'(4 * b));
            mem_rsp_last  = (b == 3);
            @(negedge clk_in);
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_last  = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a);
        req_accept(a);
        beats(a, 0, 4);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_last = 1'b0;
        pred_taken = 1'b0; pred_target = '0; disp_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk_in);

        chk("rst_pc", pred_pc, 32'h0);
        chk("rst_req_vld", 32'(mem_req_valid), 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'h0);
        chk("rst_disp_vld", 32'(disp_valid), 32'd0);
        chk("rst_disp_pc", disp_pc, 32'h0);
        chk("rst_disp_inst", disp_inst, 32'h0);

        // Cold start: miss at first cycle, request visible one cycle later.
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("cold_req_vld", 32'(mem_req_valid), 32'd1);
        chk("cold_req_addr", mem_req_addr, 32'h0);
        chk("cold_miss_inst", pred_inst, 32'h0);
        rdy_in = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk_in);
        chk("frozen_req_vld", 32'(mem_req_valid), 32'd1);
        chk("frozen_req_addr", mem_req_addr, 32'h0);
        rdy_in = 1'b1; mem_req_ready = 1'b0;
        fill(32'h0);
        chk("after_fill_pc", pred_pc, 32'h0);
        chk("after_fill_hit", pred_inst, memw(32'h0));
        chk("after_fill_dvld", 32'(disp_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            disp_chk("cold", 32'(4 * i), 1'b0);
        end
        chk("pc10", pred_pc, 32'h10);
        chk("pc10_miss", pred_inst, 32'h0);
        @(negedge clk_in);
        chk("req10_vld", 32'(mem_req_valid), 32'd1);
        chk("req10_addr", mem_req_addr, 32'h10);
        chk("empty_dvld", 32'(disp_valid), 32'd0);

        // Redirect back to 0x8 while the 0x10 request waits, then predict taken to 0x40.
        redirect_valid = 1'b1; redirect_pc = 32'h8; disp_ready = 1'b0;
        @(negedge clk_in);
        redirect_valid = 1'b0;
        chk("pc8", pred_pc, 32'h8);
        chk("pc8_hit", pred_inst, memw(32'h8));
        pred_taken = 1'b1; pred_target = 32'h40;
        @(negedge clk_in);
        pred_taken = 1'b0;
        disp_chk("taken", 32'h8, 1'b1);
        chk("pc40", pred_pc, 32'h40);
        chk("pc40_miss", pred_inst, 32'h0);
        chk("req10_stable", mem_req_addr, 32'h10);
        fill(32'h10);

        // Redirect to 0x100 during the 0x40 fill.
        req_accept(32'h40);
        beats(32'h40, 0, 2);
        chk("pre_redir_dvld", 32'(disp_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        mem_rsp_valid = 1'b1; mem_rsp_data = memw(32'h48); mem_rsp_last = 1'b0;
        #1;
        chk("redir_dvld", 32'(disp_valid), 32'd0);
        @(negedge clk_in);
        redirect_valid = 1'b0;
        mem_rsp_data = memw(32'h4C); mem_rsp_last = 1'b1;
        chk("post_redir_dvld", 32'(disp_valid), 32'd0);
        chk("post_redir_pc", pred_pc, 32'h100);
        @(negedge clk_in);
        mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;

        // Fill queue with 0x100..0x11C while dispatch is stalled.
        fill(32'h100);
        fill(32'h110);
        fill(32'h120);
        @(negedge clk_in);
        chk("full_pc", pred_pc, 32'h120);
        chk("full_hit", pred_inst, memw(32'h120));
        chk("full_head", disp_pc, 32'h100);
        @(negedge clk_in);
        chk("full_pc_hold", pred_pc, 32'h120);
        disp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            disp_chk("drain", 32'h100 + 32'(4 * i), 1'b0);
            @(negedge clk_in);
        end
        chk("wrap_head", disp_pc, 32'h120);

        // Line 0x40 must be installed despite the redirect.
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk_in);
        chk("l40_pc", pred_pc, 32'h40);
        chk("l40_hit", pred_inst, memw(32'h40));
        chk("l40_dvld", 32'(disp_valid), 32'd0);
        redirect_pc = 32'h400;
        @(negedge clk_in);
        redirect_valid = 1'b0;
        chk("alias_pc", pred_pc, 32'h400);
        chk("alias_miss", pred_inst, 32'h0);
        chk("req130_addr", mem_req_addr, 32'h130);
        fill(32'h130);
        fill(32'h400);
        chk("alias_hit", pred_inst, memw(32'h400));
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(negedge clk_in);
        redirect_valid = 1'b0;
        chk("evict_pc", pred_pc, 32'h0);
        chk("evict_miss", pred_inst, 32'h0);

        // Reset between beats 2 and 3 of the 0x0 refill.
        req_accept(32'h0);
        beats(32'h0, 0, 2);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_pc", pred_pc, 32'h0);
        chk("mid_rst_req_vld", 32'(mem_req_valid), 32'd0);
        chk("mid_rst_req_addr", mem_req_addr, 32'h0);
        chk("mid_rst_dvld", 32'(disp_valid), 32'd0);
        chk("mid_rst_dpc", disp_pc, 32'h0);
        chk("mid_rst_dinst", disp_inst, 32'h0);
        chk("mid_rst_dft", disp_fallthrough, 32'h0);
        mem_rsp_valid = 1'b1; mem_rsp_data = memw(32'h8); mem_rsp_last = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        mem_rsp_data = memw(32'hC); mem_rsp_last = 1'b1;
        @(negedge clk_in);
        mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
        chk("post_rst_miss", pred_inst, 32'h0);
        chk("post_rst_req_vld", 32'(mem_req_valid), 32'd1);
        chk("post_rst_req_addr", mem_req_addr, 32'h0);
        fill(32'h0);
        @(negedge clk_in);
        disp_chk("refetch", 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address and instruction width in bits.
REQ-002 SHALL have parameter ICACHE_LINES, 64, direct-mapped line count (power of 2, >=2).
REQ-003 SHALL have parameter LINE_WORDS, 4, 32-bit words per line (power of 2, >=1).
REQ-004 SHALL have parameter IQ_DEPTH, 8, instruction queue entries (power of 2, >=2).
REQ-005 SHALL have parameter RESET_PC, 0, PC loaded on reset.
REQ-006 SHALL have port clk_in, input, 1, the only clock.
REQ-007 SHALL have port rst_in, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rdy_in, input, 1, global enable; low freezes all state.
REQ-009 SHALL have port mem_req_valid, output, 1, line refill request.
REQ-010 SHALL have port mem_req_addr, output, ADDR_W, line-aligned refill address.
REQ-011 SHALL have port mem_req_ready, input, 1, memory accepts request.
REQ-012 SHALL have port mem_rsp_valid, input, 1, one refill word this cycle.
REQ-013 SHALL have port mem_rsp_data, input, 32, refill word, ascending address order.
REQ-014 SHALL have port mem_rsp_last, input, 1, final word of line.
REQ-015 SHALL have ports pred_pc (output, ADDR_W) and pred_inst (output, 32): current PC and its cached instruction (0 on miss).
REQ-016 SHALL have ports pred_taken (input, 1) and pred_target (input, ADDR_W): combinational prediction, absolute target.
REQ-017 SHALL have ports disp_valid (output, 1) and disp_ready (input, 1): dispatch handshake.
REQ-018 SHALL have ports disp_inst (32), disp_pc, disp_fallthrough (ADDR_W) and disp_pred_taken (1), all outputs, head-entry payload.
REQ-019 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, ADDR_W): rollback from ROB.

Function
REQ-020 SHALL index cache by pc[2+log2(LINE_WORDS) +: log2(ICACHE_LINES)], word by pc[2 +: log2(LINE_WORDS)], tag by remaining upper bits; hit = line valid and tag equal.
REQ-021 SHALL, on hit and queue not full, enqueue {inst, pc, pred_taken, pc+4} and set pc to pred_taken ? pred_target : pc+4 next cycle.
REQ-022 SHALL not enqueue when queue is full (count==IQ_DEPTH), even with simultaneous dequeue; pc holds.
REQ-023 SHALL implement queue as circular buffer with head/tail wrapping modulo IQ_DEPTH; simultaneous enqueue and dequeue leaves count unchanged.
REQ-024 SHALL drive disp_valid = (count!=0) && !redirect_valid; dequeue when disp_valid && disp_ready; payload from registered head entry.
REQ-025 SHALL run refill FSM IDLE -> REQ -> FILL -> IDLE.
REQ-026 SHALL in IDLE on miss go to REQ next cycle, latching line-aligned pc as mem_req_addr.
REQ-027 SHALL in REQ hold mem_req_valid high and mem_req_addr stable until mem_req_ready, then enter FILL.
REQ-028 SHALL in FILL write each mem_rsp_valid word at word offset = beat count (wraps at LINE_WORDS); on mem_rsp_last set tag and valid, return to IDLE.
REQ-029 SHALL keep line invalid during FILL, so no partial-line hit.
REQ-030 SHALL on redirect_valid: empty queue, pc <= redirect_pc, no enqueue or dequeue that cycle; in-flight REQ/FILL completes and installs its line.
REQ-031 SHALL, if redirect pc misses while FILL is busy, start new refill only after return to IDLE.
REQ-032 SHALL give latency: hit at cycle N -> disp_valid at N+1 (queue empty before); miss at N -> mem_req_valid at N+1; last beat at M -> hit possible at M+1.
REQ-033 SHALL, with rdy_in low, hold all registers; mem_req_valid remains as last registered.

Reset
REQ-034 SHALL on rst_in asynchronously set pc=RESET_PC, all line valid bits 0, queue empty, FSM IDLE, mem_req_valid=0, mem_req_addr=0, all disp_* payload=0.
REQ-035 SHALL, with reset mid-FILL, discard partial line and ignore later mem_rsp beats until a new request is accepted.

Verification
REQ-036 Cold start, RESET_PC=0x0, memory ready next cycle, 4 beats -> mem_req_addr=0x0, then 0x0,0x4,0x8,0xC dispatched in order, one per cycle, disp_ready=1.
REQ-037 pred_taken=1, pred_target=0x40 at pc 0x8 -> entry pc 0x8 disp_pred_taken=1, fallthrough 0xC; next enqueued pc 0x40 (miss, request 0x40).
REQ-038 disp_ready=0 with IQ_DEPTH=8 -> count stops at 8, pc frozen; ready=1 -> 8 entries out in order, head wraps, no loss or duplication.
REQ-039 redirect_valid with pc=0x100 during FILL of 0x40 -> disp_valid low that cycle, queue empty, line 0x40 still installed, then request 0x100.
REQ-040 Aliasing 0x0 and 0x400 (ICACHE_LINES=64, LINE_WORDS=4) -> second fetch misses, refills, evicts; returning to 0x0 misses again.
REQ-041 rst_in asserted between beats 2 and 3 of a fill -> line 0x0 invalid, all outputs reset values immediately, refetch from RESET_PC.
